// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with tear-free frame-boundary value loading.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          DIG_ACT_HIGH = 1'b1
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load_req,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic                    load_ack,
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    seg_blank,
  output logic                    frame_done
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(PRESCALE - 1);
  localparam logic [DigW-1:0] DigLast   = DigW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DigOff = DIG_ACT_HIGH ? '0 : '1;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DigW-1:0]         digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [3:0]              hex_d;
  logic [NUM_DIGITS-1:0]   dig_en_d;
  logic                    seg_blank_d, frame_done_d, load_ack_d;
  logic                    capture;
  logic                    lit_d;
  logic [3:0]              nibble_d;
  logic [NUM_DIGITS-1:0]   onehot_d;
`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0]   suppress_d;
  logic                    hi_zero;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      digit_q    <= '0;
      disp_q     <= '0;
      hex_out    <= 4'h0;
      dig_en     <= DigOff;
      seg_blank  <= 1'b1;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      disp_q     <= disp_d;
      hex_out    <= hex_d;
      dig_en     <= dig_en_d;
      seg_blank  <= seg_blank_d;
      frame_done <= frame_done_d;
      load_ack   <= load_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = '0;
          digit_d = '0;
        end
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BlankLast) state_d = StDrive;
        end
        StDrive: begin
          if (cnt_q == SlotLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            digit_d = (digit_q == DigLast) ? '0 : digit_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // The boundary cycle is exactly the cycle frame_done is high, independent of enable.
  always_comb begin
    capture = load_req && (state_q == StIdle || frame_done);
    disp_d  = capture ? value_in : disp_q;

    nibble_d = 4'h0;
    onehot_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_d == DigW'(i)) begin
        nibble_d    = disp_d[4*i +: 4];
        onehot_d[i] = 1'b1;
      end
    end

`ifdef SEG_SCAN_LZB_EN
    suppress_d = '0;
    hi_zero    = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero       = hi_zero && (disp_d[4*i +: 4] == 4'h0);
      suppress_d[i] = hi_zero;
    end
    lit_d = (state_d == StDrive) && ((suppress_d & onehot_d) == '0);
`else
    lit_d = (state_d == StDrive);
`endif

    hex_d        = (state_d == StBlank && cnt_d == '0) ? nibble_d : hex_out;
    dig_en_d     = lit_d ? (DIG_ACT_HIGH ? onehot_d : ~onehot_d) : DigOff;
    seg_blank_d  = !lit_d;
    frame_done_d = (state_d == StDrive) && (digit_d == DigLast) && (cnt_d == SlotLast);
    load_ack_d   = capture;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-frame slot expectations are queued when a value
// takes effect and compared cycle by cycle as the display scans.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic          sys_clk = 1'b0;
  logic          reset, enable, load_req;
  logic [15:0]   value_in;
  logic          load_ack, seg_blank, frame_done;
  logic [3:0]    hex_out, dig_en;
  logic          load_ack_n, seg_blank_n, frame_done_n;
  logic [3:0]    hex_out_n, dig_en_n;

  typedef struct {
    logic [3:0] hex;
    bit         lit;
  } slot_t;

  slot_t       sb_q[$];
  logic [15:0] cur_val;
  bit          ack_pend;
  int          checks = 0;
  int          failures = 0;

  always #5 sys_clk = ~sys_clk;

  seg_scan_ctrl #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .DIG_ACT_HIGH(1'b1)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .enable(enable), .load_req(load_req),
    .value_in(value_in), .load_ack(load_ack), .hex_out(hex_out), .dig_en(dig_en),
    .seg_blank(seg_blank), .frame_done(frame_done)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .DIG_ACT_HIGH(1'b0)
  ) dut_n (
    .sys_clk(sys_clk), .reset(reset), .enable(enable), .load_req(load_req),
    .value_in(value_in), .load_ack(load_ack_n), .hex_out(hex_out_n), .dig_en(dig_en_n),
    .seg_blank(seg_blank_n), .frame_done(frame_done_n)
  );

  task automatic push_frame(input logic [15:0] val);
    slot_t s;
    for (int i = 0; i < N; i++) begin
      s.hex = val[4*i +: 4];
`ifdef SEG_SCAN_LZB_EN
      s.lit = !((i > 0) && ((val >> (4*i)) == 16'h0));
`else
      s.lit = 1'b1;
`endif
      sb_q.push_back(s);
    end
  endtask

  // Called at the sample point of digit 0, slot cycle 0; returns at the next frame's start.
  task automatic check_frame(input int raise_at, input int drop_at, input logic [15:0] req_val);
    slot_t      e;
    bit         on;
    logic [3:0] mask;
    for (int d = 0; d < N; d++) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty d%0d: got size 0 want >0", d);
        e.hex = 4'hx;
        e.lit = 1'b0;
      end else begin
        e = sb_q.pop_front();
      end
      for (int c = 0; c < P; c++) begin
        on   = (c >= B) && e.lit;
        mask = on ? (4'b0001 << d) : 4'b0000;
        checks++;
        if (hex_out !== e.hex) begin
          failures++;
          $display("FAIL hex_out d%0d c%0d: got %h want %h", d, c, hex_out, e.hex);
        end
        checks++;
        if (dig_en !== mask) begin
          failures++;
          $display("FAIL dig_en d%0d c%0d: got %b want %b", d, c, dig_en, mask);
        end
        checks++;
        if (dig_en_n !== ~mask) begin
          failures++;
          $display("FAIL dig_en_low d%0d c%0d: got %b want %b", d, c, dig_en_n, ~mask);
        end
        checks++;
        if (seg_blank !== !on) begin
          failures++;
          $display("FAIL seg_blank d%0d c%0d: got %b want %b", d, c, seg_blank, !on);
        end
        checks++;
        if (frame_done !== (d == N - 1 && c == P - 1)) begin
          failures++;
          $display("FAIL frame_done d%0d c%0d: got %b want %b", d, c, frame_done,
                   (d == N - 1 && c == P - 1));
        end
        checks++;
        if (load_ack !== (d == 0 && c == 0 && ack_pend)) begin
          failures++;
          $display("FAIL load_ack d%0d c%0d: got %b want %b", d, c, load_ack,
                   (d == 0 && c == 0 && ack_pend));
        end
        if (d == 0 && c == 0) ack_pend = 1'b0;
        if (c == 0 && d == raise_at) begin
          load_req = 1'b1;
          value_in = req_val;
        end
        if (c == 0 && d == drop_at) load_req = 1'b0;
        if (d == N - 1 && c == P - 1) begin
          if (load_req) begin
            cur_val  = value_in;
            ack_pend = 1'b1;
          end
          push_frame(cur_val);
        end
        @(negedge sys_clk);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; load_req = 1'b0; value_in = 16'h0;
    cur_val = 16'h0; ack_pend = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (dig_en !== 4'b0000) begin
      failures++; $display("FAIL reset_dig_en: got %b want 0000", dig_en);
    end
    checks++;
    if (dig_en_n !== 4'b1111) begin
      failures++; $display("FAIL reset_dig_en_low: got %b want 1111", dig_en_n);
    end
    checks++;
    if ({hex_out, seg_blank, load_ack, frame_done} !== 7'b0000_100) begin
      failures++;
      $display("FAIL reset_outputs: got hex=%h blank=%b ack=%b fd=%b want 0 1 0 0",
               hex_out, seg_blank, load_ack, frame_done);
    end
    reset = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_idle_load;
    load_req = 1'b1;
    value_in = 16'h1234;
    @(negedge sys_clk);
    checks++;
    if (load_ack !== 1'b1) begin
      failures++; $display("FAIL idle_ack: got %b want 1", load_ack);
    end
    load_req = 1'b0;
    cur_val  = 16'h1234;
    @(negedge sys_clk);
    checks++;
    if (load_ack !== 1'b0) begin
      failures++; $display("FAIL idle_ack_clear: got %b want 0", load_ack);
    end
    checks++;
    if (dig_en !== 4'b0000 || seg_blank !== 1'b1) begin
      failures++; $display("FAIL idle_dark: got %b/%b want 0000/1", dig_en, seg_blank);
    end
  endtask

  task automatic test_scan_order;
    push_frame(cur_val);
    enable = 1'b1;
    @(negedge sys_clk);
    check_frame(-1, -1, 16'h0);
    check_frame(-1, -1, 16'h0);
  endtask

  task automatic test_tear_free;
    check_frame(1, -1, 16'hABCD);
    check_frame(-1, 0, 16'h0);
  endtask

  task automatic test_withdrawn;
    check_frame(1, 2, 16'h5678);
    check_frame(-1, -1, 16'h0);
  endtask

  task automatic test_lzb;
    check_frame(0, -1, 16'h0050);
    check_frame(-1, 0, 16'h0);
    check_frame(0, -1, 16'h0000);
    check_frame(-1, 0, 16'h0);
  endtask

  task automatic test_enable_drop;
    repeat (2 * P + 4) @(negedge sys_clk);
    enable = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (dig_en !== 4'b0000 || dig_en_n !== 4'b1111 || seg_blank !== 1'b1) begin
      failures++;
      $display("FAIL enable_drop_idle: got %b/%b/%b want 0000/1111/1",
               dig_en, dig_en_n, seg_blank);
    end
    repeat (2) @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b0 || dig_en !== 4'b0000) begin
      failures++;
      $display("FAIL enable_drop_hold: got fd=%b dig=%b want 0 0000", frame_done, dig_en);
    end
    sb_q.delete();
    push_frame(cur_val);
    enable = 1'b1;
    @(negedge sys_clk);
    check_frame(0, -1, 16'h9876);
    check_frame(-1, 0, 16'h0);
  endtask

  task automatic test_reset_mid;
    repeat (P + 4) @(negedge sys_clk);
    checks++;
    if (dig_en !== 4'b0010 || hex_out !== 4'h7) begin
      failures++;
      $display("FAIL pre_reset_drive: got %b/%h want 0010/7", dig_en, hex_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dig_en !== 4'b0000 || dig_en_n !== 4'b1111) begin
      failures++; $display("FAIL mid_reset_dig_en: got %b/%b want 0000/1111", dig_en, dig_en_n);
    end
    checks++;
    if (seg_blank !== 1'b1 || hex_out !== 4'h0 || load_ack !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got blank=%b hex=%h ack=%b fd=%b want 1 0 0 0",
               seg_blank, hex_out, load_ack, frame_done);
    end
    @(negedge sys_clk);
    reset = 1'b0;
    sb_q.delete();
    cur_val  = 16'h0;
    ack_pend = 1'b0;
    push_frame(cur_val);
    @(negedge sys_clk);
    check_frame(-1, -1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_scan_order();
    test_tear_free();
    test_withdrawn();
    test_lzb();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the stopwatch's multi-digit seven-segment display. Holds a frame-stable copy of the packed BCD/hex display value and, once per digit slot, presents one nibble on `hex_out` to the `seg_display` decoder while driving the matching digit enable. Each slot has a dead-time interval to suppress ghosting. Display updates are accepted through a request/acknowledge handshake at frame boundaries only, so a frame is never torn.

## Interface
- `NUM_DIGITS`, 4: digits scanned; index 0 is least significant.
- `PRESCALE`, 1000: `sys_clk` cycles per digit slot; must exceed `BLANK_CYCLES`.
- `BLANK_CYCLES`, 16: dead-time cycles at the start of each slot; minimum 1.
- `DIG_ACT_HIGH`, 1: 1 means `dig_en` is active-high; 0 means active-low.

Ports:
- `sys_clk` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run scanning; low forces IDLE.
- `load_req` in 1: level request to replace the display value.
- `value_in` in 4*NUM_DIGITS: new value; nibble i goes to digit i.
- `load_ack` out 1: one-cycle pulse when `value_in` is captured.
- `hex_out` out 4: nibble for `seg_display.hex_in`.
- `dig_en` out NUM_DIGITS: one-hot digit enable, with polarity set by `DIG_ACT_HIGH`.
- `seg_blank` out 1: high when no digit is lit (dead time, IDLE, or a suppressed digit).
- `frame_done` out 1: one-cycle pulse on the last cycle of the final digit slot.

## Operation
- **States.**
  - IDLE: counters cleared, all digits inactive.
  - BLANK: dead time; all digits inactive; `hex_out` already shows the current digit's nibble.
  - DRIVE: the current digit is active.
- **Transitions.**
  - IDLE→BLANK when `enable` is high; starts at digit 0 with slot count 0.
  - BLANK→DRIVE when slot count reaches BLANK_CYCLES-1.
  - DRIVE→BLANK on slot count PRESCALE-1. The digit index increments and wraps from NUM_DIGITS-1 to 0.
  - Any state→IDLE on the first cycle `enable` is sampled low.
- **Counters.** Slot counter width is $clog2(PRESCALE). Digit index width is $clog2(NUM_DIGITS), minimum 1. The slot counter resets to 0 at each slot start.
- **Capture while running.** If `load_req` is high on the frame-boundary cycle (the cycle `frame_done` pulses), `value_in` is captured into the display register. `load_ack` pulses in the following cycle. The new frame's first slot (digit 0) uses the new value.
- **Capture in IDLE.** `load_req` high captures on the next edge and `load_ack` pulses one cycle later. Requests continue while `load_req` stays high, one capture per eligible cycle.
- **Withdrawn request.** If `load_req` drops before a boundary, nothing is captured.
- **Simultaneous events.** If `enable` falls on a boundary cycle with `load_req` high, the boundary capture still happens and IDLE follows.
- **Reset values** (applied asynchronously):
  - state IDLE, digit index 0, slot count 0
  - display register 0, `hex_out`=0
  - `dig_en` all inactive (all 0 when DIG_ACT_HIGH=1, all 1 when DIG_ACT_HIGH=0)
  - `seg_blank`=1, `load_ack`=0, `frame_done`=0
- **Reset mid-slot** aborts immediately. Scanning resumes from digit 0 only after `reset` falls and `enable` is sampled high.

## Timing
- All outputs are registered.
- Let `enable` be sampled high at edge k:
  - BLANK for digit 0 runs from k.
  - `dig_en[0]` goes active at edge k+BLANK_CYCLES and stays active for PRESCALE-BLANK_CYCLES cycles.
- Slot period is PRESCALE cycles; frame period is NUM_DIGITS*PRESCALE cycles.
- `hex_out` changes only on slot entry (the first BLANK cycle). It is stable for the whole slot.
- `load_ack` latency is 1 cycle after capture. The worst-case wait from request to capture is one frame period.

## Configuration
- Macro: `SEG_SCAN_LZB_EN` (leading-zero blanking).
- **Defined:** digit i>0 is suppressed when nibble i and every higher nibble are 0. Digit 0 is never suppressed.
  - During a suppressed digit's DRIVE, `dig_en` stays inactive and `seg_blank` stays 1.
  - Slot timing and `frame_done` are unchanged.
- **Undefined:** every digit is driven in its slot regardless of value. The suppression logic is absent.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
- **Reset:** assert `reset` mid-DRIVE → `dig_en`=4'b0000, `seg_blank`=1, `hex_out`=0 before the next edge. Release with `enable` high → `dig_en[0]` active 2 cycles later.
- **Scan order:** value 16'h1234 loaded in IDLE, then `enable` → `hex_out` sequence 4,3,2,1. `dig_en` runs 0001, 0010, 0100, 1000, each active for 6 cycles after 2 blank cycles. `frame_done` pulses every 32 cycles.
- **Tear-free load:** `load_req` with 16'hABCD raised at digit 1 → no change to the current frame. `load_ack` pulses 1 cycle after `frame_done`. Next frame shows D, C, B, A. Dropping `load_req` before the boundary gives no ack and no change.
- **Leading-zero blanking** (macro defined):
  - 16'h0050 → digits 3 and 2 stay dark with `seg_blank`=1; digit 1 shows 5; digit 0 shows 0.
  - 16'h0000 → only digit 0 lights.
  - Macro undefined → all four digits light.
- **Enable drop:** `enable` low at slot count 4 of digit 2 → IDLE next cycle with all digits inactive. Re-enable → restarts at digit 0 BLANK.
- **Polarity:** DIG_ACT_HIGH=0 → reset value of `dig_en` is 4'b1111. Digit 0 active shows as 4'b1110.
